// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: round-robin arbiter for the single register-file write port.
// Port 0 is the pipeline WB stage and port 1 is the interrupt/context unit.
// The winning write is registered into an output stage that drives the
// register file. Per-port saturating grant counters are provided for debug.
module reg_wb_arbiter #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned OP_W   = 3,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk_50MHz,
    input  logic              rst,
    input  logic              hold,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [OP_W-1:0]   req0_op,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [OP_W-1:0]   req1_op,
    output logic              req1_ready,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic [OP_W-1:0]   reg_op,
    output logic              last_grant,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1
);

    // REG_OP_NOP code from the CPU's register-op encoding.
    localparam logic [OP_W-1:0]  REG_OP_NOP = {OP_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    logic              grant0_s;
    logic              grant1_s;
    logic              xfer_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [DATA_W-1:0] win_data_s;
    logic [OP_W-1:0]   win_op_s;

    logic [ADDR_W-1:0] wb_addr_r;
    logic [DATA_W-1:0] wb_data_r;
    logic [OP_W-1:0]   reg_op_r;
    logic              last_grant_r;
    logic [CNT_W-1:0]  grant_cnt0_r;
    logic [CNT_W-1:0]  grant_cnt1_r;

    // Saturating increment for the debug grant counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (value == CNT_MAX) begin
            sat_inc = CNT_MAX;
        end else begin
            sat_inc = value + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Round-robin grant: on a tie the port that did not win last time wins;
    // reset low or hold high suppresses every grant so requesters retry.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (!rst || hold) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if (req0_valid && req1_valid) begin
            if (last_grant_r) begin
                grant0_s = 1'b1;
            end else begin
                grant1_s = 1'b1;
            end
        end else if (req0_valid) begin
            grant0_s = 1'b1;
        end else if (req1_valid) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Winner mux feeding the output stage.
    always_comb begin
        xfer_s     = grant0_s | grant1_s;
        win_addr_s = req0_addr;
        win_data_s = req0_data;
        win_op_s   = req0_op;
        if (grant1_s) begin
            win_addr_s = req1_addr;
            win_data_s = req1_data;
            win_op_s   = req1_op;
        end else begin
            win_addr_s = req0_addr;
            win_data_s = req0_data;
            win_op_s   = req0_op;
        end
    end

    // Output stage: load the winner on a transfer, otherwise emit NOP and
    // keep the last address/data so the register-file bus does not toggle.
    always_ff @(posedge clk_50MHz) begin
        if (!rst) begin
            wb_addr_r <= {ADDR_W{1'b0}};
            wb_data_r <= {DATA_W{1'b0}};
            reg_op_r  <= REG_OP_NOP;
        end else if (xfer_s) begin
            wb_addr_r <= win_addr_s;
            wb_data_r <= win_data_s;
            reg_op_r  <= win_op_s;
        end else begin
            reg_op_r  <= REG_OP_NOP;
        end
    end

    // Priority pointer: resets to 1 so port 0 wins the first tie.
    always_ff @(posedge clk_50MHz) begin
        if (!rst) begin
            last_grant_r <= 1'b1;
        end else if (xfer_s) begin
            last_grant_r <= grant1_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // Per-port saturating grant counters for debug visibility.
    always_ff @(posedge clk_50MHz) begin
        if (!rst) begin
            grant_cnt0_r <= {CNT_W{1'b0}};
            grant_cnt1_r <= {CNT_W{1'b0}};
        end else begin
            if (grant0_s) begin
                grant_cnt0_r <= sat_inc(grant_cnt0_r);
            end
            if (grant1_s) begin
                grant_cnt1_r <= sat_inc(grant_cnt1_r);
            end
        end
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;
    assign wb_addr    = wb_addr_r;
    assign wb_data    = wb_data_r;
    assign reg_op     = reg_op_r;
    assign last_grant = last_grant_r;
    assign grant_cnt0 = grant_cnt0_r;
    assign grant_cnt1 = grant_cnt1_r;

endmodule

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

Write-port arbiter for the CPU register file. Two writeback requesters share the file's single write port (wb_addr / wb_data / reg_op): the pipeline WB stage (port 0) and the interrupt/context unit (port 1). The block arbitrates round-robin and registers the winning write into an output stage that drives the register file. It also exposes per-port grant counters for debug.

## Interface
Parameters:
- DATA_W, 16, width of write data (matches `DATA_BUS`)
- ADDR_W, 3, width of general-register address (matches `REG_ADDR_BUS`)
- OP_W, 3, width of register-op code (matches `REG_OP_BUS`); codes are the `REG_OP_*` values from define.v
- CNT_W, 8, width of saturating grant counters

Ports:
- clk_50MHz  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous active-low reset
- hold  in  1  freeze: no grants while high
- req0_valid  in  1  port 0 (pipeline WB) request
- req0_addr  in  ADDR_W  port 0 general-register address
- req0_data  in  DATA_W  port 0 write data
- req0_op  in  OP_W  port 0 register op
- req0_ready  out  1  port 0 granted this cycle
- req1_valid / req1_addr / req1_data / req1_op  in  1 / ADDR_W / DATA_W / OP_W  port 1 (context unit), same meaning
- req1_ready  out  1  port 1 granted this cycle
- wb_addr  out  ADDR_W  to register file
- wb_data  out  DATA_W  to register file
- reg_op  out  OP_W  to register file; `REG_OP_NOP` when idle
- last_grant  out  1  port index of most recent grant
- grant_cnt0 / grant_cnt1  out  CNT_W  saturating grant counts per port

## Operation
- Grant logic is combinational from req*_valid, hold, rst and the priority pointer `last_grant`.
- hold=1 or rst=0: no grant; req0_ready=req1_ready=0.
- Only one port valid: that port is granted.
- Both ports valid: the port ≠ last_grant is granted (round-robin).
- reqN_ready = grantN. A transfer occurs when valid & ready in the same cycle. The requester holds addr/data/op stable while valid & !ready.
- On a transfer at a rising edge:
  - wb_addr, wb_data and reg_op are loaded from the winner.
  - last_grant is loaded with the winner's index.
  - The winner's counter increments and saturates at 2^CNT_W-1.
- No transfer at a rising edge: reg_op is loaded with `REG_OP_NOP`. wb_addr and wb_data hold their previous values.
- A request whose op is `REG_OP_NOP` is still a transfer: it is granted, counted and advances the pointer, and it emits NOP.
- Special-register ops (T/SP/IH/RA) pass through unchanged. The addr field is forwarded but is don't-care for those ops.
- Nothing is buffered beyond the single output stage. An ungranted request simply waits.

## Timing
- Reset: at a rising edge with rst=0:
  - reg_op=`REG_OP_NOP`, wb_addr=0, wb_data=0
  - last_grant=1, so port 0 wins the first tie
  - grant_cnt0=grant_cnt1=0
- Reset mid-transfer: a grant that would coincide with rst=0 is suppressed (ready is low), so the requester must retry.
- Latency: request accepted at edge k → reg_op/wb_* valid from edge k to edge k+1.
- The register file samples on the falling edge, half a cycle after the output stage updates. Each accepted write is therefore committed exactly once, in the cycle after acceptance.
- Throughput: one write per cycle. With both ports continuously valid, grants strictly alternate 0,1,0,1…
- hold asserted for n cycles produces exactly n NOP output cycles (after the one-cycle pipeline delay). Arbitration resumes with last_grant unchanged.
- Counter saturation: at 255 (CNT_W=8) further grants leave the count at 255. The pointer and output behave normally.

## Test plan
- Reset: drive rst=0 for 2 edges with both ports valid → both ready=0, reg_op=NOP, wb_addr=0, wb_data=0, counters 0, last_grant=1.
- Single port: req0 valid, addr=3, data=0x1234, op=`REG_OP_REG` → req0_ready=1 that cycle. Next cycle wb_addr=3, wb_data=0x1234, reg_op=`REG_OP_REG`; register-file readback of r3 = 0x1234. grant_cnt0=1.
- Contention: both valid for 4 cycles (port 0 r1=0x0001, port 1 op `REG_OP_SP` data=0xBF00) → grants 0,1,0,1. Outputs alternate; grant_cnt0=grant_cnt1=2.
- Hold: both valid, hold=1 for 3 cycles → ready low, 3 NOP cycles, counters unchanged. On release the port ≠ last_grant is granted first.
- NOP request: req1 valid with op=`REG_OP_NOP` alone → granted, reg_op=NOP next cycle, grant_cnt1 increments, last_grant=1.
- Saturation: 300 back-to-back port-0 grants → grant_cnt0=255, and the last write data appears on wb_data.
